prio_irq_encoder: RTL and testbench
===================================

Name: prio_irq_encoder

Overview:
- Parametrised, registered successor to the team's 4:2 combinational priority encoder.
- Latches N request lines into sticky pending bits and applies an enable mask.
- Selects one pending source by fixed or round-robin priority and presents its binary index with a valid/ack handshake.
- Sits between peripheral event lines and the controller FSM that services them.

Parameters:
- N, 8, number of request channels; legal range 2..32.
- IW, $clog2(N), index width; derived, not overridden.
- RR_MODE, 0, 0 = fixed priority (highest index wins); 1 = rotating priority.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request pulses or levels; bit i set for any cycle marks channel i pending.
- mask  input  N  per-channel enable; 1 = eligible for selection; masked bits still latch.
- ack  input  1  consumer accepts the presented index; effective only while valid=1.
- valid  output  1  index is valid and stable.
- index  output  IW  binary number of the selected channel.
- zero  output  1  registered; 1 when no eligible pending bit exists.
- pending  output  N  current sticky pending register, unmasked.

Behaviour:
- Reset, checked at every clock edge, takes priority over all other activity:
  - pending=0, valid=0, index=0, zero=1, rr_ptr=N-1.
  - Reset mid-handshake discards the presented index; an ack in the same cycle is ignored.
- Pending update each cycle: pending <= (pending & ~clr) | req.
  - clr is one-hot(index) when ack && valid, else 0.
  - If req[index] is high in the ack cycle, that bit stays set; a new request wins over the clear.
- Eligible vector: E = pending & mask.
- Selection:
  - RR_MODE=0: highest set bit of E.
  - RR_MODE=1: first set bit of E scanning downward from rr_ptr, wrapping N-1 -> 0.
  - On each accepted ack of index k, rr_ptr <= (k==0) ? N-1 : k-1, so channel k becomes lowest priority.
  - rr_ptr is unchanged in fixed mode.
- Output state machine, two states:
  - IDLE (valid=0): if E!=0, load index=sel and set valid=1, moving to PRESENT. Otherwise stay; index holds its last value.
  - PRESENT (valid=1): index, valid and rr_ptr are frozen regardless of new req or mask changes. On ack, go to IDLE with valid=0.
  - After an ack there is always one bubble cycle of valid=0, so back-to-back grants are issued every 2 cycles minimum.
  - Masking the presented channel while in PRESENT does not withdraw it.
- zero <= ((pending_next & mask) == 0), registered, so it tracks the pending register with no extra lag.
- Latency: req high at edge t sets pending after edge t. valid/index appear after edge t+1 if the block was in IDLE.
- ack while valid=0 has no effect.
- All N requests at once: fixed mode grants N-1 first. Round-robin after reset also grants N-1 first.
- N not a power of two: index never exceeds N-1.

Test Plan:
1. N=8, RR_MODE=0, mask=8'hFF, reset then req=8'b0000_0101 for 1 cycle -> pending=05 next cycle; valid=1, index=2 the cycle after; zero=0.
2. Same state, ack for 1 cycle -> pending=01; valid=0 one cycle; then index=0, valid=1; after ack -> pending=00, zero=1, valid stays 0.
3. Fixed mode, req=8'hFF held 1 cycle, then ack asserted whenever valid=1 -> grant sequence 7,6,5,4,3,2,1,0, every 2 cycles.
4. RR_MODE=1, req=8'b1000_0011 held continuously, ack on every valid -> grants 7,1,0,7,1,0, demonstrating the wrap.
5. Mask: pending=8'h30, mask=8'h0F -> valid stays 0, zero=1, pending=30. Set mask=8'hFF -> index=5, valid=1 within 1 cycle of the change.
6. Edge cases:
   - Assert rst while valid=1 with ack=1 -> next cycle pending=00, valid=0, zero=1.
   - req[index]=1 in the ack cycle -> bit stays pending and is re-granted after the bubble.

Source files
------------

// File: rtl/prio_irq_encoder_if.sv
// Request/grant bundle between peripheral event lines, the priority encoder
// and the controller that services the granted channel.
interface prio_irq_encoder_if #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic          ack;
  logic          valid;
  logic [IW-1:0] index;
  logic          zero;
  logic [N-1:0]  pending;

  modport master (output req, mask, ack, input valid, index, zero, pending);
  modport slave  (input req, mask, ack, output valid, index, zero, pending);
endinterface

// File: rtl/prio_irq_encoder.sv
// Registered priority encoder: sticky pending bits, enable mask, fixed or
// rotating selection, and a valid/ack handshake with a one-cycle bubble.
module prio_irq_encoder #(
  parameter int N       = 8,
  parameter int RR_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  prio_irq_encoder_if.slave  bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  state_t        r_state;
  logic          r_valid;
  logic [IW-1:0] r_index;
  logic          r_zero;
  logic [N-1:0]  r_pending;
  logic [IW-1:0] r_rr_ptr;

  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_pend_next;
  logic [IW-1:0] w_sel;
  logic          w_accept;

  assign w_elig      = r_pending & bus.mask;
  assign w_accept    = bus.ack && r_valid;
  assign w_pend_next = (r_pending & ~w_clr) | bus.req;

  always_comb begin
    w_clr = '0;
    if (w_accept) w_clr[r_index] = 1'b1;
  end

  // Fixed: last hit in an upward scan is the highest index.
  // Rotating: first hit scanning down from r_rr_ptr with wrap.
  always_comb begin
    int  j;
    logic found;
    w_sel = '0;
    found = 1'b0;
    j     = 0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < N; i++) begin
        j = int'(r_rr_ptr) - i;
        if (j < 0) j = j + N;
        if (!found && w_elig[j]) begin
          w_sel = IW'(j);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (w_elig[i]) w_sel = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_index   <= '0;
      r_zero    <= 1'b1;
      r_pending <= '0;
      r_rr_ptr  <= IW'(N - 1);
    end else begin
      r_pending <= w_pend_next;
      r_zero    <= ((w_pend_next & bus.mask) == '0);
      case (r_state)
        S_IDLE: begin
          if (w_elig != '0) begin
            r_index <= w_sel;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // Presented index stays frozen until accepted, even if masked.
          if (bus.ack) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
            if (RR_MODE != 0)
              r_rr_ptr <= (r_index == '0) ? IW'(N - 1) : r_index - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid   = r_valid;
  assign bus.index   = r_index;
  assign bus.zero    = r_zero;
  assign bus.pending = r_pending;
endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed bench: a cycle table on a fixed-priority instance, then grant
// sequences on fixed and rotating instances.
module tb_prio_irq_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prio_irq_encoder_if #(.N(8)) bf ();
  prio_irq_encoder_if #(.N(8)) br ();

  prio_irq_encoder #(.N(8), .RR_MODE(0)) u_fix (.clk(clk), .rst(rst), .bus(bf));
  prio_irq_encoder #(.N(8), .RR_MODE(1)) u_rr  (.clk(clk), .rst(rst), .bus(br));

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       v;
    logic [2:0] idx;
    logic       z;
    logic [7:0] p;
  } vec_t;

  vec_t tbl [24];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic grant_seq(input bit rr, input int n, input int exp [8], input string tag);
    int k = 0;
    int last = -1;
    logic v;
    logic [2:0] ix;
    for (int c = 0; c < 40 && k < n; c++) begin
      @(posedge clk); #1;
      v  = rr ? br.valid : bf.valid;
      ix = rr ? br.index : bf.index;
      if (v) begin
        chk($sformatf("%s_grant%0d", tag, k), 32'(ix), 32'(exp[k]));
        if (k > 0) chk($sformatf("%s_gap%0d", tag, k), 32'(c - last), 32'd2);
        last = c;
        k++;
      end
      if (rr) br.ack = v; else bf.ack = v;
    end
    chk({tag, "_count"}, 32'(k), 32'(n));
    @(posedge clk); #1;
    bf.ack = 1'b0;
    br.ack = 1'b0;
  endtask

  initial begin
    int e3 [8];
    int e4 [8];
    bf.req = '0; bf.mask = 8'hFF; bf.ack = 1'b0;
    br.req = '0; br.mask = 8'hFF; br.ack = 1'b0;

    //           rst req    mask   ack  v  idx z  pending
    tbl[0]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00};
    tbl[1]  = '{1'b0, 8'h05, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 8'h05};
    tbl[2]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd2, 1'b0, 8'h05};
    tbl[3]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 1'b0, 8'h01};
    tbl[4]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01};
    tbl[5]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00};
    tbl[8]  = '{1'b0, 8'h30, 8'h0F, 1'b0, 1'b0, 3'd0, 1'b1, 8'h30};
    tbl[9]  = '{1'b0, 8'h00, 8'h0F, 1'b0, 1'b0, 3'd0, 1'b1, 8'h30};
    tbl[10] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 1'b0, 8'h30};
    tbl[11] = '{1'b0, 8'h00, 8'h0F, 1'b0, 1'b1, 3'd5, 1'b1, 8'h30};
    tbl[12] = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 1'b0, 8'h10};
    tbl[13] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd4, 1'b0, 8'h10};
    tbl[14] = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd4, 1'b1, 8'h00};
    tbl[15] = '{1'b0, 8'h04, 8'hFF, 1'b0, 1'b0, 3'd4, 1'b0, 8'h04};
    tbl[16] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd2, 1'b0, 8'h04};
    tbl[17] = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00};
    tbl[18] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00};
    tbl[19] = '{1'b0, 8'h08, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08};
    tbl[20] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
    tbl[21] = '{1'b0, 8'h08, 8'hFF, 1'b1, 1'b0, 3'd3, 1'b0, 8'h08};
    tbl[22] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
    tbl[23] = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 1'b1, 8'h00};

    for (int i = 0; i < 24; i++) begin
      rst     = tbl[i].rst;
      bf.req  = tbl[i].req;
      bf.mask = tbl[i].mask;
      bf.ack  = tbl[i].ack;
      @(posedge clk); #1;
      chk($sformatf("row%0d_valid", i),   32'(bf.valid),   32'(tbl[i].v));
      chk($sformatf("row%0d_index", i),   32'(bf.index),   32'(tbl[i].idx));
      chk($sformatf("row%0d_zero", i),    32'(bf.zero),    32'(tbl[i].z));
      chk($sformatf("row%0d_pending", i), 32'(bf.pending), 32'(tbl[i].p));
    end
    bf.req = '0; bf.ack = 1'b0; bf.mask = 8'hFF;

    // Fixed priority: all channels at once drain from 7 down to 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bf.req = 8'hFF;
    @(posedge clk); #1;
    bf.req = 8'h00;
    e3 = '{7, 6, 5, 4, 3, 2, 1, 0};
    grant_seq(1'b0, 8, e3, "fix_all");
    chk("fix_all_zero",    32'(bf.zero),    32'd1);
    chk("fix_all_pending", 32'(bf.pending), 32'h00);

    // Rotating priority with continuously held requests shows the wrap.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    br.req = 8'b1000_0011;
    @(posedge clk); #1;
    e4 = '{7, 1, 0, 7, 1, 0, 0, 0};
    grant_seq(1'b1, 6, e4, "rr_wrap");
    chk("rr_wrap_pending", 32'(br.pending), 32'h83);
    br.req = 8'h00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
